// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer for a one-cycle synchronous-read ROM, feeding decode via a 2-entry buffer.
// Optional feature: define IFETCH_HALT_EN to stop fetching when HALT_WORD is pushed into the buffer.
module ifetch_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    output logic              halted,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fptr;
    logic [ADDR_W-1:0] ifl_pc;
    logic              inflight;
    logic [1:0]        count;
    logic [DATA_W-1:0] buf_instr [2];
    logic [ADDR_W-1:0] buf_pc    [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] occupancy;

    // Handshake: the head transfers at a rising edge where out_valid and out_ready are both high;
    // out_valid never depends on out_ready, and the head stays stable until it transfers or a
    // redirect/reset flushes it.
    assign out_valid = (count != 2'd0);
    assign out_instr = buf_instr[0];
    assign out_pc    = buf_pc[0];
    assign mem_addr  = fptr;
    assign fsm_state = state;

    assign pop       = out_valid && out_ready;
    assign occupancy = count + {1'b0, inflight};
    // Slot 0 is always the head; an issue is allowed only when the word it fetches has a slot waiting.
    assign issue     = ((state == S_RUN) || ((state == S_IDLE) && start)) &&
                       ((occupancy <= 2'd1) || pop);

`ifdef IFETCH_HALT_EN
    logic push_is_halt;
    // Data returning while halted belongs to an issue made at the halt edge and is dropped.
    assign push         = inflight && (state != S_HALT);
    assign push_is_halt = push && (mem_data == HALT_WORD);
`else
    logic unused_halt_word;
    assign push             = inflight;
    assign halted           = 1'b0;
    assign unused_halt_word = ^HALT_WORD;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            fptr         <= RESET_PC;
            ifl_pc       <= '0;
            inflight     <= 1'b0;
            count        <= 2'd0;
            buf_instr[0] <= '0;
            buf_instr[1] <= '0;
            buf_pc[0]    <= '0;
            buf_pc[1]    <= '0;
`ifdef IFETCH_HALT_EN
            halted       <= 1'b0;
`endif
        end else if (redirect_valid) begin
            state    <= S_RUN;
            fptr     <= redirect_pc;
            inflight <= 1'b0;
            count    <= 2'd0;
`ifdef IFETCH_HALT_EN
            halted   <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                ifl_pc <= fptr;
                fptr   <= fptr + ADDR_W'(1);
            end
            if ((state == S_IDLE) && start) begin
                state <= S_RUN;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        buf_instr[0] <= mem_data;
                        buf_pc[0]    <= ifl_pc;
                    end else begin
                        buf_instr[1] <= mem_data;
                        buf_pc[1]    <= ifl_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    buf_instr[0] <= buf_instr[1];
                    buf_pc[0]    <= buf_pc[1];
                    count        <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the pushed word lands behind whatever remains.
                    if (count == 2'd1) begin
                        buf_instr[0] <= mem_data;
                        buf_pc[0]    <= ifl_pc;
                    end else begin
                        buf_instr[0] <= buf_instr[1];
                        buf_pc[0]    <= buf_pc[1];
                        buf_instr[1] <= mem_data;
                        buf_pc[1]    <= ifl_pc;
                    end
                end
                default: ;
            endcase
`ifdef IFETCH_HALT_EN
            if (push_is_halt) begin
                state  <= S_HALT;
                halted <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: ROM model, directed timing steps, randomized stall/redirect run against
// an in-order stream model. Halt behaviour is checked according to IFETCH_HALT_EN.
module tb_ifetch_ctrl;

    localparam logic [7:0]  RESET_PC  = 8'h00;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`ifdef IFETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [7:0]  out_pc;
    logic        out_ready = 1'b1;
    logic        halted;
    logic [1:0]  fsm_state;

    logic [31:0] rom [256];

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    // Reference model: the delivered stream is consecutive PCs from the last start/redirect point.
    logic [7:0] exp_q[$];
    logic [7:0] stream_next = 8'h00;
    bit         model_live   = 1'b0;
    bit         model_idle   = 1'b1;
    bit         model_halted = 1'b0;

    ifetch_ctrl #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .RESET_PC (RESET_PC),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_ready     (out_ready),
        .halted        (halted),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= rom[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void refill();
        while (model_live && !model_halted && exp_q.size() < 4) begin
            exp_q.push_back(stream_next);
            if (HALT_EN && rom[stream_next] == HALT_WORD) model_halted = 1'b1;
            stream_next = stream_next + 8'd1;
        end
    endfunction

    // One clock: update the model with what the DUT will see at this edge, then advance.
    task automatic step();
        logic [7:0] e;
        if (rst) begin
            exp_q.delete();
            model_live   = 1'b0;
            model_idle   = 1'b1;
            model_halted = 1'b0;
        end else if (redirect_valid) begin
            exp_q.delete();
            stream_next  = redirect_pc;
            model_live   = 1'b1;
            model_idle   = 1'b0;
            model_halted = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pop_pc", 32'(out_pc), 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", 32'(out_pc), 32'(e));
                    check("pop_instr", out_instr, rom[e]);
                end
            end
            if (start && model_idle) begin
                model_idle  = 1'b0;
                model_live  = 1'b1;
                stream_next = RESET_PC;
            end
        end
        @(posedge clk);
        #1;
        refill();
    endtask

    initial begin
        int p0;
        for (int n = 0; n < 256; n++) rom[n] = 32'h100 + 32'(n);

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'(RESET_PC));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", 32'(out_pc), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_valid", 32'(out_valid), 32'd0);
            check("idle_addr", 32'(mem_addr), 32'(RESET_PC));
        end

        // Start: two-cycle latency, then one instruction per cycle
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_lat_e", 32'(out_valid), 32'd0);
        check("start_state", 32'(fsm_state), 32'd1);
        step();
        check("start_lat_e1", 32'(out_valid), 32'd1);
        check("first_pc", 32'(out_pc), 32'h0);
        check("first_instr", out_instr, 32'h100);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_pc", 32'(out_pc), 32'(i + 1));
        end

        // Stall to fill the buffer, then reset mid-operation
        out_ready = 1'b0;
        step();
        step();
        step();
        p0 = int'(mem_addr);
        step();
        check("stall_addr_hold", 32'(mem_addr), 32'(p0));
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'(RESET_PC));
        check("midrst_state", 32'(fsm_state), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_quiet", 32'(out_valid), 32'd0);
        end

        // Start with decode stalled for 5 cycles after the first valid
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("stall_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) step();
        check("stall_full_addr", 32'(mem_addr), 32'h02);
        check("stall_head_pc", 32'(out_pc), 32'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("release_pc", 32'(out_pc), 32'(i));
            step();
            check("release_valid", 32'(out_valid), 32'd1);
        end

        // Redirect to 8'h40 with the buffer full
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc = 8'h40;
        out_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        check("redir_drop_valid", 32'(out_valid), 32'd0);
        check("redir_addr", 32'(mem_addr), 32'h40);
        step();
        check("redir_r1_valid", 32'(out_valid), 32'd0);
        check("redir_r1_addr", 32'(mem_addr), 32'h41);
        step();
        check("redir_r2_valid", 32'(out_valid), 32'd1);
        check("redir_r2_pc", 32'(out_pc), 32'h40);
        check("redir_r2_instr", out_instr, 32'h140);
        for (int i = 0; i < 3; i++) step();

        // Address wrap FE, FF, 00, 01
        redirect_valid = 1'b1;
        redirect_pc = 8'hFE;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        check("wrap_pc0", 32'(out_pc), 32'hFE);
        step();
        check("wrap_pc1", 32'(out_pc), 32'hFF);
        step();
        check("wrap_pc2", 32'(out_pc), 32'h00);
        check("wrap_instr2", out_instr, 32'h100);
        step();
        check("wrap_pc3", 32'(out_pc), 32'h01);
        check("wrap_valid", 32'(out_valid), 32'd1);

        // Randomized stalls, redirects and stray starts
        p0 = pops;
        for (int i = 0; i < 300; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = 8'($urandom_range(0, 255));
            start          = ($urandom_range(0, 7) == 0);
            step();
        end
        redirect_valid = 1'b0;
        start = 1'b0;
        check("rand_progress", 32'(pops - p0 >= 100), 32'd1);

        // HALT_WORD at address 3
        rom[3] = HALT_WORD;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        step();
        redirect_valid = 1'b0;
        p0 = pops;
        for (int i = 0; i < 12; i++) step();
`ifdef IFETCH_HALT_EN
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_state", 32'(fsm_state), 32'd2);
        check("halt_drained", 32'(exp_q.size()), 32'd0);
        check("halt_count", 32'(pops - p0), 32'd4);
        check("halt_quiet", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 8'h00;
        step();
        redirect_valid = 1'b0;
        check("unhalt_flag", 32'(halted), 32'd0);
        check("unhalt_state", 32'(fsm_state), 32'd1);
        step();
        step();
        check("unhalt_pc", 32'(out_pc), 32'h00);
        check("unhalt_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 8; i++) step();
`else
        check("nohalt_flag", 32'(halted), 32'd0);
        check("nohalt_progress", 32'(pops - p0 >= 8), 32'd1);
        check("nohalt_valid", 32'(out_valid), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
